// File: rtl/ov7725_dvp_tx.sv
// OV7725-style DVP RGB565 frame source: VSYNC/HREF timing plus a byte stream
// taken from a synchronous pixel RAM or from an internal 8-bar colour pattern.
module ov7725_dvp_tx #(
    parameter int H_ACTIVE = 320,
    parameter int V_ACTIVE = 240,
    parameter int H_BLANK  = 144,
    parameter int VS_LINES = 3,
    parameter int V_BACK   = 17,
    parameter int V_FRONT  = 10
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iEN,
    input  logic        iMODE,
    output logic        oPIX_RD,
    output logic [16:0] oPIX_ADDR,
    input  logic [15:0] iPIX_DATA,
    output logic        OV7725_VSYNC,
    output logic        OV7725_HREF,
    output logic [7:0]  OV7725_D,
    output logic        oFRAME_DONE,
    output logic        oBUSY
);
    localparam int LINE = 2*H_ACTIVE + H_BLANK;
    localparam int HW   = $clog2(LINE);
    localparam int LW   = $clog2(VS_LINES + V_BACK + V_ACTIVE + V_FRONT);
    localparam int BW   = H_ACTIVE / 8;
    localparam int BCW  = $clog2(BW + 1);
    localparam logic [HW-1:0]  H_LAST   = HW'(LINE - 1);
    localparam logic [HW-1:0]  H_HREF   = HW'(2*H_ACTIVE);
    localparam logic [BCW-1:0] BAR_LAST = BCW'(BW - 1);

    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_e;

    typedef struct packed {
        logic vs;
        logic hr;
        logic hi;
        logic done;
        logic busy;
    } ctl_t;

    state_e          state_q, state_d;
    logic [HW-1:0]   h_q, h_d;
    logic [LW-1:0]   ln_q, ln_d, last_ln;
    logic            mode_q, mode_d;
    logic            line_end, frame_last;
    logic            hr0, rd0;
    logic [2:0]      bar_q;
    logic [BCW-1:0]  bcnt_q;
    logic [16:0]     addr_q;
    ctl_t            s1_q, s2_q;
    logic [15:0]     s1_bar_q, s2_bar_q, pix;
    logic [7:0]      lo_q;

    function automatic logic [15:0] bar_rgb(input logic [2:0] b);
        case (b)
            3'd0:    bar_rgb = 16'hFFFF;
            3'd1:    bar_rgb = 16'hFFE0;
            3'd2:    bar_rgb = 16'h07FF;
            3'd3:    bar_rgb = 16'h07E0;
            3'd4:    bar_rgb = 16'hF81F;
            3'd5:    bar_rgb = 16'hF800;
            3'd6:    bar_rgb = 16'h001F;
            default: bar_rgb = 16'h0000;
        endcase
    endfunction

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= IDLE;
            h_q     <= '0;
            ln_q    <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            ln_q    <= ln_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        h_d      = h_q;
        ln_d     = ln_q;
        mode_d   = mode_q;
        line_end = (h_q == H_LAST);
        unique case (state_q)
            VSYNC:   last_ln = LW'(VS_LINES - 1);
            VBACK:   last_ln = LW'(V_BACK - 1);
            ACTIVE:  last_ln = LW'(V_ACTIVE - 1);
            default: last_ln = LW'(V_FRONT - 1);
        endcase
        frame_last = (state_q == VFRONT) && line_end && (ln_q == last_ln);
        if (state_q == IDLE) begin
            if (iEN) begin
                state_d = VSYNC;
                mode_d  = iMODE;
                h_d     = '0;
                ln_d    = '0;
            end
        end else begin
            h_d = line_end ? '0 : h_q + 1'b1;
            if (line_end) begin
                ln_d = (ln_q == last_ln) ? '0 : ln_q + 1'b1;
                if (ln_q == last_ln) begin
                    unique case (state_q)
                        VSYNC:  state_d = VBACK;
                        VBACK:  state_d = ACTIVE;
                        ACTIVE: state_d = VFRONT;
                        default: begin
                            // iEN is only looked at here, so a drop mid-frame never truncates it
                            state_d = iEN ? VSYNC : IDLE;
                            if (iEN) mode_d = iMODE;
                        end
                    endcase
                end
            end
        end
    end

    assign hr0 = (state_q == ACTIVE) && (h_q < H_HREF);
    assign rd0 = hr0 && !mode_q && !h_q[0];

    // Bar position tracked incrementally; restarts at every line start
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            bar_q  <= '0;
            bcnt_q <= '0;
        end else if (!hr0) begin
            bar_q  <= '0;
            bcnt_q <= '0;
        end else if (h_q[0]) begin
            if (bcnt_q == BAR_LAST) begin
                bcnt_q <= '0;
                bar_q  <= bar_q + 1'b1;
            end else begin
                bcnt_q <= bcnt_q + 1'b1;
            end
        end
    end

    // Stage 1: read strobe/address issue; stage 2: RAM data valid; stage 3: pins
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            s1_q         <= '0;
            s2_q         <= '0;
            s1_bar_q     <= '0;
            s2_bar_q     <= '0;
            addr_q       <= '0;
            lo_q         <= '0;
            oPIX_RD      <= 1'b0;
            oPIX_ADDR    <= '0;
            OV7725_VSYNC <= 1'b0;
            OV7725_HREF  <= 1'b0;
            OV7725_D     <= '0;
            oFRAME_DONE  <= 1'b0;
            oBUSY        <= 1'b0;
        end else begin
            s1_q     <= '{vs: state_q == VSYNC, hr: hr0, hi: !h_q[0],
                          done: frame_last, busy: state_q != IDLE};
            s1_bar_q <= bar_rgb(bar_q);
            oPIX_RD  <= rd0;
            if (state_q == VSYNC) begin
                addr_q    <= '0;
                oPIX_ADDR <= '0;
            end else if (rd0) begin
                oPIX_ADDR <= addr_q;
                addr_q    <= addr_q + 1'b1;
            end
            s2_q     <= s1_q;
            s2_bar_q <= s1_bar_q;
            OV7725_VSYNC <= s2_q.vs;
            OV7725_HREF  <= s2_q.hr;
            oFRAME_DONE  <= s2_q.done;
            oBUSY        <= s2_q.busy;
            if (!s2_q.hr) begin
                OV7725_D <= 8'h00;
            end else if (s2_q.hi) begin
                OV7725_D <= pix[15:8];
                lo_q     <= pix[7:0];
            end else begin
                OV7725_D <= lo_q;
            end
        end
    end

    assign pix = mode_q ? s2_bar_q : iPIX_DATA;

endmodule

// File: tb/tb_ov7725_dvp_tx.sv
// Scoreboard bench for ov7725_dvp_tx on a reduced frame geometry.
module tb_ov7725_dvp_tx;
    localparam int HA = 16, VA = 4, HB = 6, VS = 2, VB = 1, VF = 2;
    localparam int LINE  = 2*HA + HB;
    localparam int FRAME = (VS + VB + VA + VF) * LINE;
    localparam int FIRST = (VS + VB) * LINE;

    logic        iCLK = 1'b0, iRST_N, iEN, iMODE;
    logic        oPIX_RD, OV7725_VSYNC, OV7725_HREF, oFRAME_DONE, oBUSY;
    logic [16:0] oPIX_ADDR;
    logic [15:0] iPIX_DATA, mem_q;
    logic [7:0]  OV7725_D;

    int n_chk = 0, n_pass = 0;
    logic [7:0] sb[$];
    bit         mq[$];

    ov7725_dvp_tx #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
                    .VS_LINES(VS), .V_BACK(VB), .V_FRONT(VF)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iEN(iEN), .iMODE(iMODE),
        .oPIX_RD(oPIX_RD), .oPIX_ADDR(oPIX_ADDR), .iPIX_DATA(iPIX_DATA),
        .OV7725_VSYNC(OV7725_VSYNC), .OV7725_HREF(OV7725_HREF), .OV7725_D(OV7725_D),
        .oFRAME_DONE(oFRAME_DONE), .oBUSY(oBUSY));

    always #5 iCLK = ~iCLK;

    // Synchronous RAM model: data = address, one clock after the strobe
    always @(posedge iCLK) if (oPIX_RD) mem_q <= oPIX_ADDR[15:0];
    assign iPIX_DATA = mem_q;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    endtask

    function automatic logic [15:0] bar_col(input int b);
        logic [15:0] tbl [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
        return tbl[b];
    endfunction

    task automatic push_frame(input bit m);
        logic [15:0] p;
        for (int l = 0; l < VA; l++)
            for (int c = 0; c < HA; c++) begin
                p = m ? bar_col(c / (HA/8)) : 16'(l*HA + c);
                sb.push_back(p[15:8]);
                sb.push_back(p[7:0]);
            end
        mq.push_back(m);
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 2*FRAME && !seen; i++) begin
            @(negedge iCLK);
            if (oFRAME_DONE) seen = 1;
        end
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_vs"},   32'(OV7725_VSYNC), 0);
        chk({tag, "_href"}, 32'(OV7725_HREF), 0);
        chk({tag, "_d"},    32'(OV7725_D), 0);
        chk({tag, "_rd"},   32'(oPIX_RD), 0);
        chk({tag, "_addr"}, 32'(oPIX_ADDR), 0);
        chk({tag, "_done"}, 32'(oFRAME_DONE), 0);
        chk({tag, "_busy"}, 32'(oBUSY), 0);
    endtask

    // Output monitor: timing, byte stream against the scoreboard, address model
    bit p_vs, p_hr, in_frame, fmode;
    int fcnt, vs_run, hr_run, hr_cnt, rd_cnt, exp_addr;
    logic [8:0] exp_b;
    always @(negedge iCLK) begin
        if (!iRST_N) begin
            p_vs = 0; p_hr = 0; in_frame = 0; fcnt = 0; vs_run = 0; hr_run = 0;
        end else begin
            if (in_frame) fcnt++;
            if (OV7725_VSYNC && !p_vs) begin
                in_frame = 1; fcnt = 0; hr_cnt = 0; rd_cnt = 0; exp_addr = 0;
                fmode = (mq.size() > 0) ? mq.pop_front() : 1'b1;
                chk("busy_in_frame", 32'(oBUSY), 1);
            end
            if (OV7725_VSYNC) vs_run++;
            else if (p_vs) begin
                chk("vs_len", 32'(vs_run), 32'(VS*LINE));
                vs_run = 0;
            end
            chk("href_in_vs", 32'(OV7725_HREF & OV7725_VSYNC), 0);
            if (OV7725_HREF) begin
                if (!p_hr) begin
                    chk("href_pos", 32'(fcnt), 32'(FIRST + hr_cnt*LINE));
                    hr_cnt++;
                end
                hr_run++;
                exp_b = (sb.size() > 0) ? {1'b0, sb.pop_front()} : 9'h100;
                chk("pix_byte", {23'd0, 1'b0, OV7725_D}, {23'd0, exp_b});
            end else begin
                chk("d_blank", 32'(OV7725_D), 0);
                if (p_hr) begin
                    chk("href_len", 32'(hr_run), 32'(2*HA));
                    hr_run = 0;
                end
            end
            if (oPIX_RD) begin
                chk("rd_addr", 32'(oPIX_ADDR), 32'(exp_addr));
                chk("rd_mode", 32'(fmode), 0);
                exp_addr++; rd_cnt++;
            end
            if (oFRAME_DONE) begin
                chk("done_at", 32'(fcnt), 32'(FRAME - 1));
                chk("lines", 32'(hr_cnt), 32'(VA));
                chk("rd_cnt", 32'(rd_cnt), fmode ? 0 : 32'(VA*HA));
                in_frame = 0;
            end
            p_vs = OV7725_VSYNC;
            p_hr = OV7725_HREF;
        end
    end

    initial begin
        iRST_N = 1'b0; iEN = 1'b0; iMODE = 1'b0;
        repeat (3) @(negedge iCLK);
        chk_zero("rst");

        // Memory frame, then a bar frame chained with no gap; iMODE flips mid-frame
        push_frame(1'b0);
        iEN = 1'b1; iRST_N = 1'b1;
        repeat (150) @(negedge iCLK);
        iMODE = 1'b1;
        push_frame(1'b1);
        wait_done();
        @(negedge iCLK);
        chk("b2b_vs", 32'(OV7725_VSYNC), 1);
        chk("b2b_busy", 32'(oBUSY), 1);

        // Drop iEN during active line 2: the frame still completes
        repeat (FIRST + 2*LINE + 5) @(negedge iCLK);
        iEN = 1'b0;
        wait_done();
        repeat (5) @(negedge iCLK);
        chk("idle_vs", 32'(OV7725_VSYNC), 0);
        chk("idle_busy", 32'(oBUSY), 0);
        repeat (60) @(negedge iCLK);
        chk("idle_vs_late", 32'(OV7725_VSYNC), 0);

        // Reset mid-line aborts; next frame restarts at address 0
        iMODE = 1'b0; iEN = 1'b1;
        push_frame(1'b0);
        repeat (FIRST + LINE + 10) @(negedge iCLK);
        chk("pre_rst_href", 32'(OV7725_HREF), 1);
        @(posedge iCLK);
        #2 iRST_N = 1'b0;
        #1 chk_zero("mid_rst");
        sb.delete();
        mq.delete();
        push_frame(1'b0);
        repeat (2) @(negedge iCLK);
        iRST_N = 1'b1;
        repeat (5) @(negedge iCLK);
        iEN = 1'b0;
        wait_done();
        repeat (10) @(negedge iCLK);
        chk("end_busy", 32'(oBUSY), 0);
        chk("sb_left", 32'(sb.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ov7725_dvp_tx.md
OV7725_DVP_TX -- requirements
Module: ov7725_dvp_tx

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- H_ACTIVE, 320, active pixels per line.
- V_ACTIVE, 240, active lines per frame.
- H_BLANK, 144, blank clocks per line after HREF.
- VS_LINES, 3, lines with VSYNC high.
- V_BACK, 17, lines between VSYNC fall and first active line.
- V_FRONT, 10, lines after last active line.
REQ-002 Ports (name, direction, width, meaning), one per line:
- iCLK, in, 1, byte clock (sole clock).
- iRST_N, in, 1, reset; one clock; reset is asynchronous and active-low.
- iEN, in, 1, frame generation enable.
- iMODE, in, 1, 0 = pixels read from frame memory, 1 = internal colour bars.
- oPIX_RD, out, 1, memory read strobe.
- oPIX_ADDR, out, 17, memory pixel address.
- iPIX_DATA, in, 16, RGB565 read data.
- OV7725_VSYNC, out, 1, frame sync.
- OV7725_HREF, out, 1, line valid.
- OV7725_D, out, 8, pixel byte.
- oFRAME_DONE, out, 1, end-of-frame pulse.
- oBUSY, out, 1, frame in progress.

Function
REQ-003 Block SHALL emit OV7725 DVP RGB565 frames, each sampled by a capture block on the iCLK rising edge, one byte per clock.
REQ-004 Line length SHALL be 2*H_ACTIVE+H_BLANK clocks (784 at default); HREF SHALL be high for the first 2*H_ACTIVE clocks of each active line, low otherwise.
REQ-005 Frame SHALL be VS_LINES+V_BACK+V_ACTIVE+V_FRONT lines (270 at default); VSYNC SHALL be high for exactly VS_LINES*line-length clocks starting on the first frame clock; HREF SHALL never be high while VSYNC is high.
REQ-006 FSM states: IDLE, VSYNC, VBACK, ACTIVE, VFRONT; IDLE->VSYNC when iEN=1; VSYNC->VBACK->ACTIVE->VFRONT after the respective line counts; VFRONT->VSYNC if iEN=1 on the last VFRONT clock, else ->IDLE.
REQ-007 Each pixel SHALL occupy two consecutive HREF-high clocks: high byte [15:8] first, then low byte [7:0].
REQ-008 OV7725_D SHALL be 8'h00 whenever HREF is low.
REQ-009 iMODE SHALL be sampled only on the IDLE->VSYNC or VFRONT->VSYNC transition and held for the whole frame.
REQ-010 Memory mode: oPIX_RD SHALL pulse one clock per pixel. iPIX_DATA SHALL be captured exactly one clock after oPIX_RD (synchronous-RAM latency). The high byte of that pixel SHALL appear on OV7725_D exactly two clocks after oPIX_RD.
REQ-011 oPIX_ADDR SHALL be 0 for the first pixel of each frame and increment by 1 per pixel across lines, reaching H_ACTIVE*V_ACTIVE-1 (76799) on the last pixel; there is no wrap within a frame; it returns to 0 at the next frame.
REQ-012 Colour-bar mode: oPIX_RD SHALL stay 0; the pixel value SHALL be bar index = pixel column/(H_ACTIVE/8), with bars 0..7 = FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
REQ-013 oFRAME_DONE SHALL pulse high for one clock on the last clock of VFRONT.
REQ-014 oBUSY SHALL be 1 in every state except IDLE.
REQ-015 iEN deasserted mid-frame SHALL NOT truncate the frame; the frame completes, then the FSM enters IDLE.
REQ-016 With iEN held high, frames SHALL be back-to-back with no idle clock between the last VFRONT clock and the next VSYNC rise.
REQ-017 All outputs SHALL be registered.

Reset
REQ-018 While iRST_N=0, all outputs SHALL go immediately to reset values: VSYNC 0, HREF 0, D 8'h00, oPIX_RD 0, oPIX_ADDR 0, oFRAME_DONE 0, oBUSY 0. The FSM SHALL be in IDLE and all counters 0.
REQ-019 Reset asserted mid-frame SHALL abort the frame. After release with iEN=1, a fresh frame SHALL start with VSYNC, beginning at address 0.

Verification
REQ-020 Reset release, iEN=1, iMODE=0 -> VSYNC high for 2352 clocks; 240 HREF pulses of 640 clocks each, spaced 784 clocks apart; oFRAME_DONE after 211680 clocks.
REQ-021 Memory model returns data=addr[15:0] one clock after oPIX_RD -> bytes sequence 00,00,00,01,... and the final pixel of the frame (address 76799) reads as 2B,FF.
REQ-022 iMODE=1 -> oPIX_RD never asserts; line bytes are FF,FF ×40 pixels, then FF,E0 ×40, ..., then 00,00 ×40.
REQ-023 iEN dropped during line 100 of ACTIVE -> frame completes with all 240 lines, oFRAME_DONE pulses, then VSYNC stays 0 and oBUSY 0.
REQ-024 iRST_N pulsed low mid-line -> outputs are 0 within the same clock; after release the next frame restarts at address 0.
REQ-025 iMODE toggled mid-frame -> no change until the next frame start; iEN held high -> consecutive frames have zero gap.
